mul_seq: RTL and testbench

- Multi-cycle radix-2 shift-add multiplier for the EX stage. It is the multiply counterpart of the array divider.
- Accepts two DATA_WIDTH operands on a start pulse, signed or unsigned, and produces a 2*DATA_WIDTH product after a fixed latency.
- Uses a start/busy/result_valid handshake with the EX-stage controller.
- Supports flush from the pipeline to abort an in-flight operation.

---
 rtl/mul_seq_pkg.sv | 21 ++
 rtl/mul_add_step.sv | 23 ++
 rtl/mul_seq.sv | 152 +++++++++++++++
 tb/tb_mul_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared definitions for the sequential shift-add multiplier:
// bus widths, FSM state encodings and small helpers.
package mul_seq_pkg;

  // Native datapath width of the EX stage and its double-width product bus.
  localparam int DATA_BUS_WIDTH        = 32;
  localparam int DOUBLE_DATA_BUS_WIDTH = 2 * DATA_BUS_WIDTH;

  // Multiplier control states; encodings are shared with the EX-stage decode.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10
  } mul_state_e;

  // The unit is busy whenever an operation is in flight.
  function automatic logic state_is_busy(input mul_state_e st);
    return (st == ST_CALC) || (st == ST_FIX);
  endfunction

endpackage : mul_seq_pkg

// File: rtl/mul_add_step.sv
// One radix-2 shift-add step: conditionally add the multiplicand into the
// upper half of the accumulator, then shift {carry, accumulator} right by one.
// Kept combinational and standalone so two copies can be chained per cycle.
module mul_add_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2*DATA_WIDTH-1:0] acc,
  input  logic [DATA_WIDTH-1:0]   mcand,
  input  logic                    lsb,
  output logic [2*DATA_WIDTH-1:0] acc_next
);

  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH-1:0] addend;

  // Partial product is either the multiplicand or zero; the extra bit keeps the carry.
  always_comb begin
    addend   = lsb ? mcand : '0;
    sum      = {1'b0, acc[2*DATA_WIDTH-1:DATA_WIDTH]} + {1'b0, addend};
    acc_next = {sum, acc[DATA_WIDTH-1:1]};
  end

endmodule : mul_add_step

// File: rtl/mul_seq.sv
// Multi-cycle radix-2 shift-add multiplier for the EX stage.
// Operands are reduced to magnitudes at start, multiplied unsigned over
// DATA_WIDTH cycles, and the sign is reapplied in the FIX state.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; result holds the last product
//   CALC  | one multiplier bit per cycle, LSB first, DATA_WIDTH cycles
//   FIX   | apply result sign, register product, pulse result_valid
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_BUS_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    signed_mul,
  input  logic [DATA_WIDTH-1:0]   op1,
  input  logic [DATA_WIDTH-1:0]   op2,
  input  logic                    flush,
  output logic                    busy,
  output logic                    result_valid,
  output logic [2*DATA_WIDTH-1:0] result
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(DATA_WIDTH - 1);

  mul_state_e state_q, state_d;

  logic [PW-1:0]         acc_q;
  logic [PW-1:0]         acc_next;
  logic [DATA_WIDTH-1:0] mcand_q;
  logic [DATA_WIDTH-1:0] mplier_q;
  logic                  neg_q;
  logic [CW-1:0]         count_q;
  logic [PW-1:0]         result_q;
  logic                  valid_q;

  logic                  load;
  logic                  step;
  logic                  finish;

  logic [DATA_WIDTH-1:0] op1_mag;
  logic [DATA_WIDTH-1:0] op2_mag;
  logic                  neg_start;
  logic [PW-1:0]         acc_signed;

  // Magnitudes of the operands; the most negative value maps onto itself as unsigned.
  always_comb begin
    op1_mag   = (signed_mul && op1[DATA_WIDTH-1]) ? (~op1 + DATA_WIDTH'(1)) : op1;
    op2_mag   = (signed_mul && op2[DATA_WIDTH-1]) ? (~op2 + DATA_WIDTH'(1)) : op2;
    neg_start = signed_mul && (op1[DATA_WIDTH-1] ^ op2[DATA_WIDTH-1]);
  end

  // Reapply the sign to the unsigned product.
  always_comb begin
    acc_signed = neg_q ? (~acc_q + PW'(1)) : acc_q;
  end

  mul_add_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_add_step (
    .acc      (acc_q),
    .mcand    (mcand_q),
    .lsb      (mplier_q[0]),
    .acc_next (acc_next)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control; flush always returns to IDLE without a result.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !flush) begin
          state_d = ST_CALC;
          load    = 1'b1;
        end
      end
      ST_CALC: begin
        if (flush) begin
          state_d = ST_IDLE;
        end else begin
          step = 1'b1;
          if (count_q == LAST_COUNT) begin
            state_d = ST_FIX;
          end
        end
      end
      ST_FIX: begin
        state_d = ST_IDLE;
        finish  = !flush;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Operand capture and iteration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      neg_q    <= 1'b0;
      count_q  <= '0;
    end else if (load) begin
      acc_q    <= '0;
      mcand_q  <= op1_mag;
      mplier_q <= op2_mag;
      neg_q    <= neg_start;
      count_q  <= '0;
    end else if (step) begin
      acc_q    <= acc_next;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q + CW'(1);
    end
  end

  // Product register and completion pulse; the product holds until the next FIX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= finish;
      if (finish) begin
        result_q <= acc_signed;
      end
    end
  end

  assign busy         = state_is_busy(state_q);
  assign result_valid = valid_q;
  assign result       = result_q;

endmodule : mul_seq

// File: tb/tb_mul_seq.sv
// Directed self-checking bench for mul_seq.
module tb_mul_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signed_mul;
  logic [31:0] op1;
  logic [31:0] op2;
  logic        flush;
  logic        busy;
  logic        result_valid;
  logic [63:0] result;

  int checks;
  int errors;

  mul_seq #(.DATA_WIDTH(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .signed_mul   (signed_mul),
    .op1          (op1),
    .op2          (op2),
    .flush        (flush),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; signed_mul = 1'b0; op1 = '0; op2 = '0; flush = 1'b0;
    #12;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 64'h0) begin
      errors++;
      $display("FAIL reset: busy=%b valid=%b result=%h, expected 0/0/0", busy, result_valid, result);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b valid=%b, expected 0/0", busy, result_valid);
    end
  endtask

  // Full operation: checks latency, busy duration, product and single-cycle pulse.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [63:0] exp, input string name);
    int lat;
    int busy_cnt;
    bit seen;
    @(negedge clk); op1 = a; op2 = b; signed_mul = s; start = 1'b1;
    @(negedge clk); start = 1'b0; op1 = 32'hDEAD_BEEF; op2 = 32'h1234_5678; signed_mul = ~s;
    busy_cnt = busy ? 1 : 0;
    lat = 0;
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (result_valid) begin
        seen = 1'b1;
        lat  = i;
      end else if (busy) begin
        busy_cnt++;
      end
    end
    checks++;
    if (!seen || lat != 33) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles after acceptance (seen=%0b), expected 33", name, lat, seen);
    end
    checks++;
    if (busy_cnt != 33) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d, expected 33", name, busy_cnt);
    end
    checks++;
    if (result !== exp) begin
      errors++;
      $display("FAIL %s product: got %h, expected %h", name, result, exp);
    end
    @(negedge clk);
    checks++;
    if (result_valid !== 1'b0 || busy !== 1'b0 || result !== exp) begin
      errors++;
      $display("FAIL %s pulse_hold: valid=%b busy=%b result=%h, expected 0/0/%h",
               name, result_valid, busy, result, exp);
    end
  endtask

  task automatic test_unsigned();
    run_op(32'h0000_0007, 32'h0000_0006, 1'b0, 64'h0000_0000_0000_002A, "u_basic");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "u_max");
    run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 64'h0000_0004_FFFF_FFF1, "u_big");
    run_op(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 64'h0, "u_zero");
  endtask

  task automatic test_signed();
    run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "s_mixed");
    run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_minmin");
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h0000_0000_0000_0001, "s_negneg");
    run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000, "s_maxmin");
  endtask

  task automatic test_flush();
    logic [63:0] prev;
    int pulses;
    prev = result;
    @(negedge clk); op1 = 32'd9; op2 = 32'd9; signed_mul = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy: busy=%b, expected 0", busy);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    checks++;
    if (pulses != 0 || result !== prev) begin
      errors++;
      $display("FAIL flush_no_result: pulses=%0d result=%h, expected 0 pulses and %h", pulses, result, prev);
    end
    run_op(32'd9, 32'd9, 1'b0, 64'd81, "after_flush");
  endtask

  task automatic test_back_to_back();
    int pulses;
    logic [63:0] first;
    logic [63:0] prev;
    @(negedge clk); op1 = 32'd3; op2 = 32'd4; signed_mul = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    op1 = 32'd100; op2 = 32'd100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    pulses = 0;
    first = 64'h0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (result_valid) begin
        if (pulses == 0) first = result;
        pulses++;
      end
    end
    checks++;
    if (pulses != 1 || first !== 64'd12) begin
      errors++;
      $display("FAIL start_while_busy: pulses=%0d product=%h, expected 1 and %h", pulses, first, 64'd12);
    end

    prev = result;
    @(negedge clk); op1 = 32'd5; op2 = 32'd5; start = 1'b1; flush = 1'b1;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL start_flush_busy: busy=%b, expected 0", busy);
    end
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid) pulses++;
    end
    checks++;
    if (pulses != 0 || result !== prev) begin
      errors++;
      $display("FAIL start_flush_result: pulses=%0d result=%h, expected 0 pulses and %h", pulses, result, prev);
    end
  endtask

  task automatic test_async_reset();
    int pulses;
    @(negedge clk); op1 = 32'd1000; op2 = 32'd1000; signed_mul = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || result_valid !== 1'b0 || result !== 64'h0) begin
      errors++;
      $display("FAIL async_reset: busy=%b valid=%b result=%h, expected 0/0/0", busy, result_valid, result);
    end
    @(negedge clk); rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (result_valid || busy) pulses++;
    end
    checks++;
    if (pulses != 0 || result !== 64'h0) begin
      errors++;
      $display("FAIL post_reset_quiet: active_cycles=%0d result=%h, expected 0 and 0", pulses, result);
    end
    run_op(32'd1000, 32'd1000, 1'b0, 64'd1000000, "after_reset");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_unsigned();
    test_signed();
    test_flush();
    test_back_to_back();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mul_seq
